// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - shared opcodes, M-stage FSM states and byte-enable constants
package mips_defs;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2b;

    localparam logic [3:0] BE_ALL = 4'b1111;
    localparam logic [3:0] BE_LO  = 4'b0011;
    localparam logic [3:0] BE_HI  = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    function automatic logic is_load_op(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_store_op(input logic [5:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

endpackage

// File: rtl/m_mem_lane.sv
// rtl/m_mem_lane.sv - byte-lane steering: enables, store replication, load extension, misalign
module m_mem_lane
    import mips_defs::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] read_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        rd_byte = read_data[7:0];
        case (addr_lo)
            2'd0: rd_byte = read_data[7:0];
            2'd1: rd_byte = read_data[15:8];
            2'd2: rd_byte = read_data[23:16];
            2'd3: rd_byte = read_data[31:24];
            default: rd_byte = read_data[7:0];
        endcase
        rd_half = addr_lo[1] ? read_data[31:16] : read_data[15:0];
    end

    always_comb begin
        be        = BE_ALL;
        wdata     = store_data;
        load_data = read_data;
        misalign  = 1'b0;
        case (op)
            OP_SB: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            OP_SH: begin
                be       = addr_lo[1] ? BE_HI : BE_LO;
                wdata    = {2{store_data[15:0]}};
                misalign = addr_lo[0];
            end
            OP_SW:  misalign  = |addr_lo;
            OP_LB:  load_data = {{24{rd_byte[7]}}, rd_byte};
            OP_LBU: load_data = {24'd0, rd_byte};
            OP_LH: begin
                load_data = {{16{rd_half[15]}}, rd_half};
                misalign  = addr_lo[0];
            end
            OP_LHU: begin
                load_data = {16'd0, rd_half};
                misalign  = addr_lo[0];
            end
            OP_LW:  misalign  = |addr_lo;
            default: ;
        endcase
    end

endmodule

// File: rtl/m_mem_access.sv
// rtl/m_mem_access.sv - M-stage data memory access unit: req/ack bus FSM with timeout
module m_mem_access
    import mips_defs::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  M_op,
    input  logic [31:0] M_ALU_ans,
    input  logic [31:0] M_GRF_RD2,
    input  logic        M_hold,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        M_stall,
    output logic [31:0] M_mem_rdata,
    output logic        M_addr_exc,
    output logic        M_bus_err
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    mem_state_t  state, state_nxt;
    logic [7:0]  tmo_cnt;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_load;
    logic        lane_misalign;
    logic        mem_op;
    logic        tmo_hit;

    m_mem_lane u_lane (
        .op         (M_op),
        .addr_lo    (M_ALU_ans[1:0]),
        .store_data (M_GRF_RD2),
        .read_data  (mem_rdata),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (lane_load),
        .misalign   (lane_misalign)
    );

    assign mem_op  = is_load_op(M_op) || is_store_op(M_op);
    assign tmo_hit = (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        M_stall   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_op) begin
                    M_stall   = 1'b1;
                    state_nxt = lane_misalign ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                M_stall = 1'b1;
                if (mem_ack || tmo_hit) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (!M_hold) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // M inputs are frozen by M_stall during REQ, so the lane output still describes this access
    always_ff @(posedge clk) begin
        if (!reset) begin
            tmo_cnt     <= 8'd0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'd0;
            mem_be      <= 4'd0;
            mem_wdata   <= 32'd0;
            M_mem_rdata <= 32'd0;
            M_addr_exc  <= 1'b0;
            M_bus_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_op) begin
                        tmo_cnt     <= 8'd0;
                        M_mem_rdata <= 32'd0;
                        M_bus_err   <= 1'b0;
                        M_addr_exc  <= lane_misalign;
                        if (!lane_misalign) begin
                            mem_req   <= 1'b1;
                            mem_we    <= is_store_op(M_op);
                            mem_addr  <= {M_ALU_ans[31:2], 2'b00};
                            mem_be    <= lane_be;
                            mem_wdata <= lane_wdata;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (is_load_op(M_op)) M_mem_rdata <= lane_load;
                    end else if (tmo_hit) begin
                        mem_req   <= 1'b0;
                        M_bus_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_m_mem_access.sv
// tb/tb_m_mem_access.sv - directed scoreboard bench for m_mem_access
module tb_m_mem_access;
    import mips_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  M_op;
    logic [31:0] M_ALU_ans;
    logic [31:0] M_GRF_RD2;
    logic        M_hold;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        M_stall;
    logic [31:0] M_mem_rdata;
    logic        M_addr_exc;
    logic        M_bus_err;

    m_mem_access #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .M_op        (M_op),
        .M_ALU_ans   (M_ALU_ans),
        .M_GRF_RD2   (M_GRF_RD2),
        .M_hold      (M_hold),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .M_stall     (M_stall),
        .M_mem_rdata (M_mem_rdata),
        .M_addr_exc  (M_addr_exc),
        .M_bus_err   (M_bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        exc;
        logic        err;
        int          stall;
    } res_exp_t;

    bus_exp_t bus_q[$];
    res_exp_t res_q[$];
    int checks = 0;
    int errors = 0;
    bit in_done = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string name, input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] rd2, input logic [31:0] rdata,
                          input int ack_delay, input int hold, input bit late_ack,
                          input bit expect_req, input bus_exp_t eb, input res_exp_t er);
        int       stalls = 0;
        int       reqc = 0;
        bit       seen = 0;
        bit       ended = 0;
        bus_exp_t b;
        res_exp_t r;
        logic [31:0] held;
        M_hold    = 1'b0;
        mem_ack   = 1'b0;
        M_op      = op;
        M_ALU_ans = addr;
        M_GRF_RD2 = rd2;
        mem_rdata = rdata;
        if (expect_req) bus_q.push_back(eb);
        res_q.push_back(er);
        if (in_done) @(negedge clk);
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            if (!M_stall) begin
                ended = 1;
                break;
            end
            stalls++;
            if (mem_req) begin
                if (!seen) begin
                    seen = 1;
                    if (bus_q.size() != 0) begin
                        b = bus_q.pop_front();
                        chk({name, ".we"},   {31'd0, mem_we}, {31'd0, b.we});
                        chk({name, ".addr"}, mem_addr, b.addr);
                        chk({name, ".be"},   {28'd0, mem_be}, {28'd0, b.be});
                        if (b.we) chk({name, ".wdata"}, mem_wdata, b.wdata);
                    end
                end
                mem_ack = (reqc == ack_delay);
                reqc++;
            end
            @(negedge clk);
            mem_ack = 1'b0;
        end
        chk({name, ".ended"}, {31'd0, ended}, 32'd1);
        chk({name, ".req_seen"}, {31'd0, seen}, {31'd0, expect_req});
        r = res_q.pop_front();
        chk({name, ".stall_cycles"}, stalls, r.stall);
        chk({name, ".rdata"}, M_mem_rdata, r.rdata);
        chk({name, ".addr_exc"}, {31'd0, M_addr_exc}, {31'd0, r.exc});
        chk({name, ".bus_err"}, {31'd0, M_bus_err}, {31'd0, r.err});
        chk({name, ".req_dropped"}, {31'd0, mem_req}, 32'd0);
        held = r.rdata;
        for (int h = 0; h < hold; h++) begin
            M_hold = 1'b1;
            if (late_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = ~rdata;
            end
            @(negedge clk);
            #1;
            chk({name, ".hold_rdata"}, M_mem_rdata, held);
            chk({name, ".hold_req"}, {31'd0, mem_req}, 32'd0);
            chk({name, ".hold_stall"}, {31'd0, M_stall}, 32'd0);
            chk({name, ".hold_err"}, {31'd0, M_bus_err}, {31'd0, r.err});
        end
        mem_ack = 1'b0;
        in_done = 1;
    endtask

    initial begin
        reset     = 1'b0;
        M_op      = 6'h00;
        M_ALU_ans = 32'd0;
        M_GRF_RD2 = 32'd0;
        M_hold    = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst.req",   {31'd0, mem_req}, 32'd0);
        chk("rst.stall", {31'd0, M_stall}, 32'd0);
        chk("rst.rdata", M_mem_rdata, 32'd0);
        chk("rst.exc",   {31'd0, M_addr_exc}, 32'd0);
        chk("rst.err",   {31'd0, M_bus_err}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        run_op("sw", OP_SW, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 0, 0, 0, 1,
               '{1'b1, 32'h0000_1004, 4'b1111, 32'hDEAD_BEEF}, '{32'h0, 1'b0, 1'b0, 2});
        run_op("lb", OP_LB, 32'h0000_4003, 32'h0, 32'h80FF_FF7F, 0, 0, 0, 1,
               '{1'b0, 32'h0000_4000, 4'b1111, 32'h0}, '{32'hFFFF_FF80, 1'b0, 1'b0, 2});
        run_op("lbu", OP_LBU, 32'h0000_4003, 32'h0, 32'h80FF_FF7F, 0, 0, 0, 1,
               '{1'b0, 32'h0000_4000, 4'b1111, 32'h0}, '{32'h0000_0080, 1'b0, 1'b0, 2});
        run_op("sh", OP_SH, 32'h0000_2002, 32'h0000_1234, 32'h0, 0, 0, 0, 1,
               '{1'b1, 32'h0000_2000, 4'b1100, 32'h1234_1234}, '{32'h0, 1'b0, 1'b0, 2});
        run_op("lh_mis", OP_LH, 32'h0000_2001, 32'h0000_1234, 32'h0, 0, 0, 0, 0,
               '{1'b0, 32'h0, 4'b0, 32'h0}, '{32'h0, 1'b1, 1'b0, 1});
        run_op("sb", OP_SB, 32'h0000_5001, 32'h0000_00A5, 32'h0, 1, 0, 0, 1,
               '{1'b1, 32'h0000_5000, 4'b0010, 32'hA5A5_A5A5}, '{32'h0, 1'b0, 1'b0, 3});
        run_op("lhu", OP_LHU, 32'h0000_6002, 32'h0, 32'hABCD_1234, 2, 0, 0, 1,
               '{1'b0, 32'h0000_6000, 4'b1111, 32'h0}, '{32'h0000_ABCD, 1'b0, 1'b0, 4});
        run_op("lh", OP_LH, 32'h0000_6000, 32'h0, 32'h1234_8001, 0, 0, 0, 1,
               '{1'b0, 32'h0000_6000, 4'b1111, 32'h0}, '{32'hFFFF_8001, 1'b0, 1'b0, 2});
        run_op("lw_tmo", OP_LW, 32'h0000_7000, 32'h0, 32'h5555_AAAA, -1, 2, 1, 1,
               '{1'b0, 32'h0000_7000, 4'b1111, 32'h0}, '{32'h0, 1'b0, 1'b1, 5});
        run_op("lw_hold", OP_LW, 32'h0000_8004, 32'h0, 32'h1234_5678, 0, 3, 0, 1,
               '{1'b0, 32'h0000_8004, 4'b1111, 32'h0}, '{32'h1234_5678, 1'b0, 1'b0, 2});
        run_op("sw_mis", OP_SW, 32'h0000_8006, 32'h1111_2222, 32'h0, 0, 0, 0, 0,
               '{1'b0, 32'h0, 4'b0, 32'h0}, '{32'h0, 1'b1, 1'b0, 1});

        M_hold = 1'b0;
        M_op   = 6'h00;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("nop.stall", {31'd0, M_stall}, 32'd0);
            chk("nop.req",   {31'd0, mem_req}, 32'd0);
        end

        M_op      = OP_LW;
        M_ALU_ans = 32'h0000_3000;
        mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        #1;
        chk("rstreq.req_up", {31'd0, mem_req}, 32'd1);
        reset = 1'b0;
        M_op  = 6'h00;
        @(negedge clk);
        #1;
        chk("rstreq.req",   {31'd0, mem_req}, 32'd0);
        chk("rstreq.we",    {31'd0, mem_we}, 32'd0);
        chk("rstreq.addr",  mem_addr, 32'd0);
        chk("rstreq.be",    {28'd0, mem_be}, 32'd0);
        chk("rstreq.wdata", mem_wdata, 32'd0);
        chk("rstreq.rdata", M_mem_rdata, 32'd0);
        chk("rstreq.exc",   {31'd0, M_addr_exc}, 32'd0);
        chk("rstreq.err",   {31'd0, M_bus_err}, 32'd0);
        chk("rstreq.stall", {31'd0, M_stall}, 32'd0);
        reset   = 1'b1;
        mem_ack = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("lateack.req",   {31'd0, mem_req}, 32'd0);
        chk("lateack.rdata", M_mem_rdata, 32'd0);
        chk("lateack.stall", {31'd0, M_stall}, 32'd0);
        mem_ack = 1'b0;
        in_done = 0;

        run_op("lw_post", OP_LW, 32'h0000_9000, 32'h0, 32'hCAFE_F00D, 0, 0, 0, 1,
               '{1'b0, 32'h0000_9000, 4'b1111, 32'h0}, '{32'hCAFE_F00D, 1'b0, 1'b0, 2});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
